uart_fifo: RTL and testbench
============================

# uart_fifo

Synchronous first-word-fall-through FIFO that sits on the FIFO side of the UART controller's byte-pair interfaces. One instance buffers host-to-line words and serves the controller's TX pop strobe; a second instance absorbs the controller's RX push strobe and is drained by the host. It supplies head-of-queue data and the `empty`/`full` flags the controller samples, plus level and watermark status for the host.

## Interface

Parameters:
- `WIDTH`, 16: word width in bits; matches the controller's 16-bit byte pair.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when level ≥ this value.
- `AE_THRESH`, 2: `almost_empty` asserts when level ≤ this value.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: push strobe; one word per cycle high.
- `wr_data` in WIDTH: word pushed when `wr_en` is high.
- `full` out 1: no free entries.
- `rd_en` in 1: pop strobe; it consumes the word currently on `rd_data`.
- `rd_data` out WIDTH: head word (FWFT); 0 while `empty`.
- `empty` out 1: no stored entries.
- `level` out $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `almost_full` out 1: level ≥ AF_THRESH.
- `almost_empty` out 1: level ≤ AE_THRESH.
- `overflow`, `underflow` out 1, `err_clr` in 1: present only under `UART_FIFO_ERR_EN`.

## Operation

- Storage: DEPTH×WIDTH array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. A separate `level` counter is $clog2(DEPTH)+1 bits wide.
- Push accepted: `wr_en && !full`. The array entry at the write pointer is written and the write pointer increments.
- Pop accepted: `rd_en && !empty`. The read pointer increments.
- Level update: +1 on push only, −1 on pop only, unchanged on both or neither.
- FWFT read path: `rd_data = empty ? 0 : mem[rd_ptr]`. This is a combinational read of registered storage, so the consumer latches `rd_data` in the same cycle it asserts `rd_en`.
- Flags are derived from `level`:
  - `empty` = (level == 0).
  - `full` = (level == DEPTH).
  - The watermarks compare `level` against their thresholds.
- Push while full: the write is dropped and storage and pointers are unchanged.
- Pop while empty: no effect.
- Simultaneous push and pop while full: both are accepted and level stays at DEPTH. The pop frees the entry being overwritten only after the read, so ordering is preserved.
- Simultaneous push and pop while empty: the pop is ignored and the push is accepted (level → 1).
- Reset, including mid-operation:
  - Pointers and level clear to 0.
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `rd_data`=0.
  - `overflow`=0 and `underflow`=0.
  - Array contents are not cleared.
  - `rst` takes priority over `wr_en`/`rd_en` in the same cycle.

## Timing

- Push at edge N makes the word visible on `rd_data` after edge N, with `empty` falling in the same cycle. Write-to-read latency is 1 cycle.
- Pop at edge N makes the next word (or 0 if now empty) appear after edge N.
- All flags and `level` are registered-state functions that update in the cycle after the causing edge; there are no combinational paths from `wr_en` or `rd_en` to the flags.
- Sustained throughput is one push and one pop per cycle.

## Configuration

- Macro: `UART_FIFO_ERR_EN`.
- Defined:
  - Adds sticky `overflow` (set on `wr_en && full`) and `underflow` (set on `rd_en && empty`).
  - Both flags clear on `err_clr` or `rst`.
  - If set and clear occur in the same cycle, set wins.
- Undefined: the three ports and their logic are absent, and attempted over/underflows are silently dropped.

## Structure

- Shared package `uart_pkg`:
  - `UART_WORD_W` = 16.
  - `UART_FIFO_DEPTH` = 16.
  - Typedef `uart_word_t` (logic [15:0]).
  - The parameter defaults above reference these.
- Sub-module `uart_fifo_mem`: a simple dual-port array with registered write and combinational read, kept separate so it can be swapped for an inferred RAM. All pointer, level and flag logic stays in `uart_fifo`.

## Test plan

- Reset, then idle: `empty`=1, `full`=0, `level`=0, `rd_data`=0, `almost_empty`=1.
- Push 0x1234 then 0xABCD, then pop twice with `rd_en` held:
  - `rd_data` shows 0x1234 one cycle after the first push.
  - 0xABCD follows after the first pop.
  - `empty` returns to 1 after the second pop.
- Fill DEPTH=16 words 0x0000..0x000F:
  - `almost_full` asserts at level 14 and `full` at 16.
  - A 17th push of 0xFFFF is dropped (`overflow`=1 under macro).
  - Draining yields 0x0000..0x000F in order, with the pointers wrapping.
- With the FIFO full, push and pop simultaneously for 20 cycles: `level` stays 16 and the popped sequence matches the push order across wrap-around.
- With the FIFO empty, assert `rd_en` and `wr_en` together with 0x5A5A:
  - Level becomes 1 and `rd_data`=0x5A5A.
  - `underflow`=1 under macro; `err_clr` clears it the next cycle.
- Assert `rst` mid-burst at level 7 with `wr_en` high: next cycle `level`=0, `empty`=1, and the pushed word is discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and word type used by the FIFO and its users.
package uart_pkg;
   localparam int UART_WORD_W     = 16;
   localparam int UART_FIFO_DEPTH = 16;

   typedef logic [UART_WORD_W-1:0] uart_word_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for uart_fifo: registered write, combinational read.
// Kept standalone so it can be replaced by an inferred or vendor RAM.
module uart_fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for the UART controller byte-pair interfaces.
// Optional sticky overflow/underflow flags with err_clr under UART_FIFO_ERR_EN.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH     = UART_WORD_W,
   parameter int DEPTH     = UART_FIFO_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full,
   output logic                     almost_empty
`ifdef UART_FIFO_ERR_EN
   ,
   input  logic                     err_clr,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem_rdata;
   logic             push;
   logic             pop;

   // A pop while full frees a slot in the same cycle, so the push is let through.
   assign pop  = rd_en && !empty;
   assign push = wr_en && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   assign empty        = (level == '0);
   assign full         = (level == DEPTH_L);
   assign almost_full  = (level >= AF_L);
   assign almost_empty = (level <= AE_L);
   assign rd_data      = empty ? '0 : mem_rdata;

   uart_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

`ifdef UART_FIFO_ERR_EN
   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)  overflow <= 1'b1;
         else if (err_clr)   overflow <= 1'b0;
         if (rd_en && empty) underflow <= 1'b1;
         else if (err_clr)   underflow <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   uart_word_t wr_data;
   logic       full;
   logic       rd_en;
   uart_word_t rd_data;
   logic       empty;
   logic [4:0] level;
   logic       almost_full;
   logic       almost_empty;
   logic       err_clr;
`ifdef UART_FIFO_ERR_EN
   logic       overflow;
   logic       underflow;
`endif

   always #5 clk = ~clk;

   uart_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`ifdef UART_FIFO_ERR_EN
      ,
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   int checks = 0;
   int errors = 0;

   uart_word_t q[$];
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      n = q.size();
      chk({tag, ":level"}, 32'(level), 32'(n));
      chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ":af"}, 32'(almost_full), 32'(n >= DEPTH - 2));
      chk({tag, ":ae"}, 32'(almost_empty), 32'(n <= 2));
      chk({tag, ":rd_data"}, 32'(rd_data), (n == 0) ? 32'd0 : 32'(q[0]));
`ifdef UART_FIFO_ERR_EN
      chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ":unf"}, 32'(underflow), 32'(m_unf));
`endif
   endtask

   // Drive one cycle, advance the model at the edge, then compare 1 time unit later.
   task automatic cycle(input bit we, input uart_word_t wd, input bit re,
                        input bit rs, input bit clr, input string tag);
      bit pop_ok, push_ok;
      int n;
      wr_en = we; wr_data = wd; rd_en = re; rst = rs; err_clr = clr;
      @(posedge clk);
      n = q.size();
      if (rs) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         pop_ok  = re && n > 0;
         push_ok = we && (n < DEPTH || pop_ok);
         if (we && n == DEPTH)  m_ovf = 1'b1;
         else if (clr)          m_ovf = 1'b0;
         if (re && n == 0)      m_unf = 1'b1;
         else if (clr)          m_unf = 1'b0;
         if (pop_ok)  void'(q.pop_front());
         if (push_ok) q.push_back(wd);
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0; err_clr = 1'b0;
      check_model(tag);
   endtask

   typedef struct {
      bit         we;
      uart_word_t wd;
      bit         re;
      int         exp_level;
      uart_word_t exp_data;
      bit         exp_empty;
   } vec_t;

   vec_t vecs[5];

   initial begin
      wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rst = 1'b1; err_clr = 1'b0;

      cycle(0, 16'h0, 0, 1, 0, "reset");
      cycle(0, 16'h0, 0, 0, 0, "idle");
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      chk("reset_ae", 32'(almost_empty), 32'd1);

      vecs[0] = '{1'b1, 16'h1234, 1'b0, 1, 16'h1234, 1'b0};
      vecs[1] = '{1'b1, 16'hABCD, 1'b0, 2, 16'h1234, 1'b0};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1, 16'hABCD, 1'b0};
      vecs[3] = '{1'b0, 16'h0000, 1'b1, 0, 16'h0000, 1'b1};
      vecs[4] = '{1'b0, 16'h0000, 1'b0, 0, 16'h0000, 1'b1};
      for (int i = 0; i < 5; i++) begin
         cycle(vecs[i].we, vecs[i].wd, vecs[i].re, 0, 0, "table");
         chk("tbl_level", 32'(level), 32'(vecs[i].exp_level));
         chk("tbl_data", 32'(rd_data), 32'(vecs[i].exp_data));
         chk("tbl_empty", 32'(empty), 32'(vecs[i].exp_empty));
      end

      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, uart_word_t'(i), 0, 0, 0, "fill");
         chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
      end
      chk("fill_full", 32'(full), 32'd1);
      cycle(1, 16'hFFFF, 0, 0, 0, "overpush");
      chk("drop_level", 32'(level), 32'd16);
`ifdef UART_FIFO_ERR_EN
      chk("overflow_set", 32'(overflow), 32'd1);
      cycle(0, 16'h0, 0, 0, 1, "ovf_clr");
`endif
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", 32'(rd_data), 32'(i));
         cycle(0, 16'h0, 1, 0, 0, "drain");
      end
      chk("drain_empty", 32'(empty), 32'd1);

      for (int i = 0; i < DEPTH; i++) cycle(1, uart_word_t'(16'h100 + i), 0, 0, 0, "refill");
      for (int i = 0; i < 20; i++) begin
         chk("sust_order", 32'(rd_data), 32'(16'h100 + i));
         cycle(1, uart_word_t'(16'h100 + DEPTH + i), 1, 0, 0, "sustain");
         chk("sust_level", 32'(level), 32'd16);
      end

      cycle(0, 16'h0, 0, 1, 0, "rst2");
      cycle(1, 16'h5A5A, 1, 0, 0, "empty_both");
      chk("eb_level", 32'(level), 32'd1);
      chk("eb_data", 32'(rd_data), 32'h5A5A);
`ifdef UART_FIFO_ERR_EN
      chk("underflow_set", 32'(underflow), 32'd1);
      cycle(0, 16'h0, 0, 0, 1, "unf_clr");
      chk("underflow_clr", 32'(underflow), 32'd0);
`endif

      cycle(0, 16'h0, 0, 1, 0, "rst3");
      for (int i = 0; i < 7; i++) cycle(1, uart_word_t'(16'h700 + i), 0, 0, 0, "burst");
      chk("burst_level", 32'(level), 32'd7);
      cycle(1, 16'h7777, 0, 1, 0, "mid_rst");
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_data", 32'(rd_data), 32'd0);
      cycle(1, 16'h0042, 0, 0, 0, "post_rst");
      chk("post_rst_data", 32'(rd_data), 32'h0042);

      // Random traffic; push bias drifts so both full and empty are visited.
      for (int blk = 0; blk < 15; blk++) begin
         int bias;
         bias = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 20 : 50;
         for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(99) < bias, uart_word_t'($urandom),
                  $urandom_range(99) < (100 - bias), $urandom_range(299) == 0,
                  $urandom_range(19) == 0, "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
